wb_port_arbiter: RTL



---
 rtl/wb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and packed-slice helper for the writeback port arbiter
package wb_pkg;

  localparam int WB_DATA_W   = 64;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_ZERO_REG = 0;

  // Bit offset of element idx inside a flat vector of width-bit elements.
  function automatic int slice_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker; first request at or after ptr_i wins
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_grant_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    req_dbl     = {req_i, req_i};
    // Rotating the doubled vector puts ptr_i at bit 0, so the search wraps for free.
    req_rot     = req_dbl[ptr_i +: N];
    found       = 1'b0;
    off         = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        off   = (IDX_W + 1)'(i);
      end
    end
    cand = {1'b0, ptr_i} + off;
    if (cand >= (IDX_W + 1)'(N)) begin
      cand = cand - (IDX_W + 1)'(N);
    end
    idx_o       = found ? cand[IDX_W-1:0] : '0;
    any_grant_o = found;
    grant_o     = '0;
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the register-file write port
// Define WB_FWD_EN to add rs1/rs2 bypass from the registered write.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = WB_DATA_W,
  parameter  int ADDR_W  = WB_ADDR_W,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0]         rs1_addr_i,
  input  logic [ADDR_W-1:0]         rs2_addr_i,
  input  logic [DATA_W-1:0]         rs1_raw_i,
  input  logic [DATA_W-1:0]         rs2_raw_i,
  output logic [DATA_W-1:0]         rs1_data_o,
  output logic [DATA_W-1:0]         rs2_data_o,
`endif
  output logic                      rf_we_o,
  output logic [ADDR_W-1:0]         rf_addr_o,
  output logic [DATA_W-1:0]         rf_data_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               any_grant;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]  rf_addr_q,  rf_addr_d;
  logic [DATA_W-1:0]  rf_data_q,  rf_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .idx_o       (win_idx),
    .any_grant_o (any_grant)
  );

  // Ready is masked while reset is held so no requester sees a phantom accept.
  assign req_ready_o = grant & {NUM_REQ{rst_i}};
  assign accept      = any_grant & rst_i;
  assign busy_o      = |req_valid_i;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        sel_addr = req_addr_i[slice_off(k, ADDR_W) +: ADDR_W];
        sel_data = req_data_i[slice_off(k, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      // x0 writes are consumed but never reach the register file.
      rf_we_d    = (sel_addr != ADDR_W'(WB_ZERO_REG));
      rf_addr_d  = sel_addr;
      rf_data_d  = sel_data;
      grant_id_d = win_idx;
      rr_ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_addr_o  = rf_addr_q;
  assign rf_data_o  = rf_data_q;
  assign grant_id_o = grant_id_q;

`ifdef WB_FWD_EN
  // Covers the cycle between the registered write and the register-file commit.
  assign rs1_data_o = (rf_we_q && rf_addr_q == rs1_addr_i && rs1_addr_i != ADDR_W'(WB_ZERO_REG))
                      ? rf_data_q : rs1_raw_i;
  assign rs2_data_o = (rf_we_q && rf_addr_q == rs2_addr_i && rs2_addr_i != ADDR_W'(WB_ZERO_REG))
                      ? rf_data_q : rs2_raw_i;
`endif

endmodule
